sorter_ctrl: RTL and testbench
==============================

SORTER_CTRL -- requirements
Module: sorter_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 16, number of elements per sort batch.
REQ-002 SHALL have parameter WIDTH, default 4, bits per element.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for sorter guard.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 abort  in  1  synchronous batch discard.
REQ-007 in_valid  in  1  input element valid.
REQ-008 in_ready  out  1  controller accepts input element.
REQ-009 in_data  in  WIDTH  input element.
REQ-010 out_valid  out  1  sorted element valid.
REQ-011 out_ready  in  1  consumer accepts sorted element.
REQ-012 out_data  out  WIDTH  sorted element, index 0 first.
REQ-013 srt_src  out  SIZE*WIDTH  packed batch to sorter, element i at bits [i*WIDTH +: WIDTH].
REQ-014 srt_tgt  in  SIZE*WIDTH  packed sorter result, same packing.
REQ-015 srt_guard  in  1  sorter result valid.
REQ-016 busy  out  1  high in any state except LOAD with count 0.
REQ-017 err  out  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be LOAD, WAIT, DRAIN; reset state LOAD.
REQ-019 LOAD: in_ready=1; each in_valid&&in_ready writes in_data to src[cnt], cnt increments; on the SIZE-th accept, cnt clears, go WAIT.
REQ-020 srt_src SHALL be driven directly from the src register array at all times.
REQ-021 WAIT: in_ready=0; wdog counts up each cycle; when srt_guard=1, srt_tgt SHALL be captured into dst buffer that same edge and go DRAIN.
REQ-022 WAIT: if wdog reaches TIMEOUT with srt_guard=0, set err, discard batch, go LOAD.
REQ-023 DRAIN: out_valid=1, out_data=dst[idx]; on out_valid&&out_ready idx increments; on the SIZE-th transfer idx clears, go LOAD.
REQ-024 out_data/out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 Minimum latency last input accept to first out_valid: 1 cycle when srt_guard is already high (capture on entry to WAIT +1).
REQ-026 abort=1 in any state SHALL clear cnt, idx, wdog and go LOAD next edge; abort takes priority over any simultaneous handshake; err unaffected.
REQ-027 err SHALL clear only on reset.
REQ-028 Counters SHALL be $clog2(SIZE)+1 bits wide so SIZE reaches without wrap; wdog width $clog2(TIMEOUT+1).
REQ-029 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state LOAD, cnt=idx=wdog=0, err=0, in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-031 src and dst arrays SHALL reset to 0; reset mid-batch discards all data.

Structure
REQ-032 Shared package sorter_pkg SHALL hold SIZE/WIDTH defaults and the FSM state enumeration.
REQ-033 One sub-module sorter_ctrl_wdog (timeout counter, clear/enable/expired) is natural; everything else flat.

Verification
REQ-034 Feed 16 values 15..0 with srt_guard tied 1, reference sorter attached -> out_data 0..15 in order, err=0.
REQ-035 Random in_valid gaps and out_ready backpressure (50%) on seed-255 data -> output equals sorted input, no element dropped or duplicated.
REQ-036 srt_guard held 0 after 16 inputs -> err=1 exactly 255 cycles after WAIT entry, in_ready=1 next cycle.
REQ-037 abort asserted after 7 inputs -> next 16 inputs form a fresh batch, output contains none of first 7.
REQ-038 rst_n pulsed low during DRAIN at idx=5 -> out_valid=0 immediately (async), busy=0, in_ready=1.
REQ-039 abort and out_ready together on final DRAIN element -> state LOAD, no extra transfer counted.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared defaults and FSM state encoding for the sort-batch controller.
package sorter_pkg;

    localparam int unsigned SIZE_DEF    = 16;
    localparam int unsigned WIDTH_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sorter_ctrl_wdog.sv
// Watchdog for the sorter guard: counts while enabled, flags the cycle whose edge reaches TIMEOUT.
module sorter_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (clr) begin
            wdog_q <= '0;
        end else if (en) begin
            wdog_q <= wdog_q + TW'(1);
        end
    end

    // The increment that would land on TIMEOUT is the expiry edge.
    assign expired_c = en && !clr && (wdog_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/sorter_ctrl.sv
// Batch controller around an external sorter: loads SIZE elements, waits for the
// sorter guard (with watchdog), then streams the sorted batch out index 0 first.
module sorter_ctrl
    import sorter_pkg::*;
#(
    parameter int unsigned SIZE    = SIZE_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SIZE*WIDTH-1:0] srt_src,
    input  logic [SIZE*WIDTH-1:0] srt_tgt,
    input  logic                  srt_guard,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned CW = $clog2(SIZE) + 1;
    localparam int unsigned IW = $clog2(SIZE);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    idx_inc;
    logic             err_d;
    logic [WIDTH-1:0] out_data_d;
    logic             in_ready_d, out_valid_d, busy_d;
    logic             src_we, dst_we;
    logic             wdog_clr, wdog_en, wdog_expired_c;

    logic [WIDTH-1:0] src_q [SIZE];
    logic [WIDTH-1:0] dst_q [SIZE];

    for (genvar g = 0; g < SIZE; g++) begin : g_pack
        assign srt_src[g*WIDTH +: WIDTH] = src_q[g];
    end

    assign wdog_en  = (state_q == ST_WAIT);
    assign wdog_clr = abort || (state_q != ST_WAIT) || srt_guard;

    sorter_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (wdog_clr),
        .en        (wdog_en),
        .expired_c (wdog_expired_c)
    );

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q_view();
        out_data_d = out_data;
        src_we     = 1'b0;
        dst_we     = 1'b0;
        idx_inc    = idx_q[IW-1:0] + IW'(1);

        if (abort) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        src_we = 1'b1;
                        if (cnt_q == CW'(SIZE - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (srt_guard) begin
                        dst_we     = 1'b1;
                        idx_d      = '0;
                        out_data_d = srt_tgt[WIDTH-1:0];
                        state_d    = ST_DRAIN;
                    end else if (wdog_expired_c) begin
                        err_d   = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (idx_q == CW'(SIZE - 1)) begin
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            idx_d      = idx_q + CW'(1);
                            out_data_d = dst_q[idx_inc];
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end

        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DRAIN);
        busy_d      = !((state_d == ST_LOAD) && (cnt_d == '0));
    end

    function automatic logic err_q_view();
        return err;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            idx_q     <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err       <= err_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            out_data  <= out_data_d;
        end
    end

    // Batch storage; reset wipes any partial or pending batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
            end
        end else begin
            if (src_we) begin
                src_q[cnt_q[IW-1:0]] <= in_data;
            end
            if (dst_we) begin
                for (int unsigned i = 0; i < SIZE; i++) begin
                    dst_q[i] <= srt_tgt[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_sorter_ctrl.sv
// Scoreboard bench for sorter_ctrl with a behavioural reference sorter on the srt_* port.
module tb_sorter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [63:0] srt_src;
    logic [63:0] srt_tgt;
    logic        srt_guard;
    logic        busy;
    logic        err;

    logic        guard_en;
    logic        bp_en;
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  exp_q [$];
    logic        stall;
    logic [3:0]  stall_data;

    logic [3:0] mix        [16] = '{9, 3, 12, 0, 7, 7, 15, 1, 4, 10, 2, 13, 5, 8, 14, 6};
    logic [3:0] mix_sorted [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 9, 10, 12, 13, 14, 15};

    sorter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .srt_src   (srt_src),
        .srt_tgt   (srt_tgt),
        .srt_guard (srt_guard),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_sort(input logic [63:0] s);
        logic [3:0]  a [16];
        logic [3:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 16; i++) a[i] = s[i*4 +: 4];
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        r = '0;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = a[i];
        return r;
    endfunction

    assign srt_tgt   = ref_sort(srt_src);
    assign srt_guard = guard_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output, checks hold under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(stall_data));
            end
            if (in_ready && out_valid) chk("ready_valid_excl", 64'd1, 64'd0);
            stall      = out_valid && !out_ready && !abort;
            stall_data = out_data;
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_data), 64'hdead);
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Random output backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [3:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        int gap;
        void'($urandom(255));
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; guard_en = 1'b1; bp_en = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Descending 15..0 through the reference sorter; checks minimum latency.
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        send(4'd15);
        chk("busy_loading", 64'(busy), 64'd1);
        for (int i = 14; i >= 0; i--) send(4'(i));
        chk("wait_out_valid", 64'(out_valid), 64'd0);
        chk("wait_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        wait_empty(200);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_err", 64'(err), 64'd0);

        // Input gaps plus 50% output backpressure, data with a duplicate.
        for (int i = 0; i < 16; i++) exp_q.push_back(mix_sorted[i]);
        bp_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            send(mix[i]);
        end
        wait_empty(500);
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        // Guard never arrives: err exactly 255 cycles after entering WAIT.
        guard_en = 1'b0;
        for (int i = 0; i < 16; i++) send(4'(i));
        repeat (254) @(posedge clk);
        #1;
        chk("to_err_early", 64'(err), 64'd0);
        chk("to_in_ready_early", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("to_err", 64'(err), 64'd1);
        chk("to_in_ready", 64'(in_ready), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_out_valid", 64'(out_valid), 64'd0);
        guard_en = 1'b1;

        // Abort after 7 inputs; the next 16 form a clean batch.
        for (int i = 0; i < 7; i++) send(4'(15 - i));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_in_ready", 64'(in_ready), 64'd1);
        chk("ab_err_sticky", 64'(err), 64'd1);
        for (int i = 0; i < 8; i++) begin exp_q.push_back(4'(i)); exp_q.push_back(4'(i)); end
        for (int i = 0; i < 16; i++) send(4'(i % 8));
        wait_empty(200);

        // Abort together with out_ready on the final element.
        for (int i = 0; i < 15; i++) exp_q.push_back(4'(i));
        for (int i = 15; i >= 0; i--) send(4'(i));
        wait_empty(200);
        chk("last_valid", 64'(out_valid), 64'd1);
        chk("last_data", 64'(out_data), 64'd15);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abl_out_valid", 64'(out_valid), 64'd0);
        chk("abl_in_ready", 64'(in_ready), 64'd1);
        chk("abl_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        for (int i = 15; i >= 0; i--) send(4'(i));
        wait_empty(200);

        // Asynchronous reset in DRAIN at idx 5.
        for (int i = 0; i < 5; i++) exp_q.push_back(4'(i));
        for (int i = 15; i >= 0; i--) send(4'(i));
        wait_empty(200);
        out_ready = 1'b0;
        chk("idx5_data", 64'(out_data), 64'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_err", 64'(err), 64'd0);
        chk("ar_out_data", 64'(out_data), 64'd0);
        chk("ar_srt_src", srt_src, 64'd0);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
